// File: rtl/exibidor_sequencia_if.sv
// Signal bundle between the game datapath and the colour sequencer.
// Optional erro flag exists only when VALIDA_ONEHOT_EN is defined.
interface exibidor_sequencia_if #(
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [3:0]        dados_rom;
    logic [ADDR_W-1:0] endereco;
    logic [3:0]        dados;
    logic              en;
    logic              ocupado;
    logic              pronto;
`ifdef VALIDA_ONEHOT_EN
    logic              erro;

    modport master (
        output iniciar, limite, dados_rom,
        input  endereco, dados, en, ocupado, pronto, erro
    );
    modport slave (
        input  iniciar, limite, dados_rom,
        output endereco, dados, en, ocupado, pronto, erro
    );
`else
    modport master (
        output iniciar, limite, dados_rom,
        input  endereco, dados, en, ocupado, pronto
    );
    modport slave (
        input  iniciar, limite, dados_rom,
        output endereco, dados, en, ocupado, pronto
    );
`endif
endinterface

// File: rtl/exibidor_sequencia.sv
// Plays a ROM sequence of one-hot colours onto the LED decoder: on-time, dark gap, repeat.
// Define VALIDA_ONEHOT_EN to abort with a sticky erro flag on a non-one-hot ROM word.
module exibidor_sequencia #(
    parameter int T_ACESO   = 50_000_000,
    parameter int T_APAGADO = 25_000_000,
    parameter int ADDR_W    = 4
) (
    input logic                 clock,
    input logic                 reset,
    exibidor_sequencia_if.slave bus
);
    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] FIM_ACESO   = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);

    typedef enum logic [2:0] {OCIOSO, CARREGA, ACESO, APAGADO, FIM} estado_t;

    estado_t           estado_reg, estado_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [ADDR_W-1:0] endereco_reg, endereco_next;
    logic [ADDR_W-1:0] limite_reg, limite_next;
    logic [3:0]        dados_reg, dados_next;
    logic              en_reg, en_next;
    logic              ocupado_reg, ocupado_next;
    logic              pronto_reg, pronto_next;
`ifdef VALIDA_ONEHOT_EN
    logic              erro_reg, erro_next;
    logic              rom_onehot;

    assign rom_onehot = (bus.dados_rom != 4'b0000) &&
                        ((bus.dados_rom & (bus.dados_rom - 4'd1)) == 4'b0000);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg   <= OCIOSO;
            timer_reg    <= '0;
            endereco_reg <= '0;
            limite_reg   <= '0;
            dados_reg    <= 4'b0000;
            en_reg       <= 1'b0;
            ocupado_reg  <= 1'b0;
            pronto_reg   <= 1'b0;
`ifdef VALIDA_ONEHOT_EN
            erro_reg     <= 1'b0;
`endif
        end else begin
            estado_reg   <= estado_next;
            timer_reg    <= timer_next;
            endereco_reg <= endereco_next;
            limite_reg   <= limite_next;
            dados_reg    <= dados_next;
            en_reg       <= en_next;
            ocupado_reg  <= ocupado_next;
            pronto_reg   <= pronto_next;
`ifdef VALIDA_ONEHOT_EN
            erro_reg     <= erro_next;
`endif
        end
    end

    // Outputs are computed one state ahead so each one comes straight from a flop.
    always_comb begin
        estado_next   = estado_reg;
        timer_next    = timer_reg;
        endereco_next = endereco_reg;
        limite_next   = limite_reg;
        dados_next    = dados_reg;
        en_next       = en_reg;
        ocupado_next  = ocupado_reg;
        pronto_next   = 1'b0;
`ifdef VALIDA_ONEHOT_EN
        erro_next     = erro_reg;
`endif
        case (estado_reg)
            OCIOSO: begin
                if (bus.iniciar) begin
                    limite_next   = bus.limite;
                    endereco_next = '0;
                    ocupado_next  = 1'b1;
`ifdef VALIDA_ONEHOT_EN
                    erro_next     = 1'b0;
`endif
                    estado_next   = CARREGA;
                end
            end
            CARREGA: begin
                timer_next = '0;
`ifdef VALIDA_ONEHOT_EN
                if (!rom_onehot) begin
                    dados_next  = 4'b0000;
                    en_next     = 1'b0;
                    erro_next   = 1'b1;
                    pronto_next = 1'b1;
                    estado_next = FIM;
                end else begin
                    dados_next  = bus.dados_rom;
                    en_next     = 1'b1;
                    estado_next = ACESO;
                end
`else
                dados_next  = bus.dados_rom;
                en_next     = 1'b1;
                estado_next = ACESO;
`endif
            end
            ACESO: begin
                if (timer_reg == FIM_ACESO) begin
                    en_next     = 1'b0;
                    dados_next  = 4'b0000;
                    timer_next  = '0;
                    estado_next = APAGADO;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            APAGADO: begin
                if (timer_reg == FIM_APAGADO) begin
                    timer_next = '0;
                    // Compare before incrementing so the last address never wraps.
                    if (endereco_reg == limite_reg) begin
                        pronto_next = 1'b1;
                        estado_next = FIM;
                    end else begin
                        endereco_next = endereco_reg + ADDR_W'(1);
                        estado_next   = CARREGA;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            FIM: begin
                ocupado_next = 1'b0;
                estado_next  = OCIOSO;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    assign bus.endereco = endereco_reg;
    assign bus.dados    = dados_reg;
    assign bus.en       = en_reg;
    assign bus.ocupado  = ocupado_reg;
    assign bus.pronto   = pronto_reg;
`ifdef VALIDA_ONEHOT_EN
    assign bus.erro     = erro_reg;
`endif
endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench for exibidor_sequencia: directed and randomized sequences
// compared cycle by cycle against a per-cycle arithmetic model of the display timing.
module tb_exibidor_sequencia;
    localparam int TA = 3;
    localparam int TD = 2;
    localparam int AW = 4;
    localparam int P  = 1 + TA + TD;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    exibidor_sequencia_if #(.ADDR_W(AW)) bus ();

    exibidor_sequencia #(
        .T_ACESO(TA),
        .T_APAGADO(TD),
        .ADDR_W(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    logic [3:0] rom [16];
    assign bus.dados_rom = rom[bus.endereco];

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic          en;
        logic [3:0]    dados;
        logic [AW-1:0] endereco;
        logic          ocupado;
        logic          pronto;
    } obs_t;

    // Expected outputs k cycles after the accepted start edge for a run with limite=lim.
    function automatic obs_t modelo(input int k, input int lim);
        obs_t o;
        int i;
        int p;
        o = '0;
        if (k < (lim + 1) * P) begin
            i = k / P;
            p = k % P;
            o.endereco = AW'(i);
            o.ocupado  = 1'b1;
            if (p >= 1 && p <= TA) begin
                o.en    = 1'b1;
                o.dados = rom[4'(i)];
            end
        end else if (k == (lim + 1) * P) begin
            o.endereco = AW'(lim);
            o.ocupado  = 1'b1;
            o.pronto   = 1'b1;
        end else begin
            o.endereco = AW'(lim);
        end
        return o;
    endfunction

    function automatic obs_t observa();
        obs_t o;
        o.en       = bus.en;
        o.dados    = bus.dados;
        o.endereco = bus.endereco;
        o.ocupado  = bus.ocupado;
        o.pronto   = bus.pronto;
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t exp);
        obs_t got;
        got = observa();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed={en,dados,end,ocup,pronto}=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic rom_padrao();
        for (int a = 0; a < 16; a++) rom[a] = 4'(1 << (a % 4));
    endtask

    // One full run; pulse_at re-pulses iniciar so it is sampled on edge pulse_at+1.
    task automatic run_seq(input int lim, input int pulse_at, input bit lim_rnd, input string tag);
        int npronto;
        int total;
        npronto = 0;
        total   = (lim + 1) * P;
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.limite  = AW'(lim);
        for (int k = 0; k <= total + 1; k++) begin
            @(negedge clock);
            check_obs($sformatf("%s_k%0d", tag, k), modelo(k, lim));
            if (bus.pronto) npronto++;
            bus.iniciar = (k == pulse_at);
            if (lim_rnd) bus.limite = AW'($urandom);
        end
        bus.iniciar = 1'b0;
        check_int({tag, "_pronto_count"}, npronto, 1);
`ifdef VALIDA_ONEHOT_EN
        check_int({tag, "_erro"}, int'(bus.erro), 0);
`endif
        $display("TXN %s limite=%0d repulse_at=%0d cycles=%0d pronto_pulses=%0d",
                 tag, lim, pulse_at, total + 2, npronto);
    endtask

    initial begin
        int lim;
        bus.iniciar = 1'b0;
        bus.limite  = '0;
        rom_padrao();

        // Reset held low, then idle with no start
        repeat (3) @(negedge clock);
        check_obs("reset_held", '0);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check_obs($sformatf("idle_c%0d", c), '0);
        end
`ifdef VALIDA_ONEHOT_EN
        check_int("idle_erro", int'(bus.erro), 0);
`endif
        $display("TXN reset_idle cycles=20");

        run_seq(3, -1, 1'b0, "lim3");
        run_seq(0, -1, 1'b0, "lim0");
        run_seq(15, -1, 1'b0, "lim15");
        // Re-pulse during the second element (element 1 spans k=6..11)
        run_seq(3, 8, 1'b0, "repulse_e2");

        // Reset while element 2 is lit
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.limite  = AW'(3);
        for (int k = 0; k <= 7; k++) begin
            @(negedge clock);
            bus.iniciar = 1'b0;
            check_obs($sformatf("pre_reset_k%0d", k), modelo(k, 3));
        end
        #2 reset = 1'b0;
        #1 check_obs("reset_mid_async", '0);
        @(negedge clock);
        check_obs("reset_mid_held", '0);
        reset = 1'b1;
        $display("TXN reset_mid_sequence");
        run_seq(3, -1, 1'b0, "replay");

        // Randomized ROM contents, limite, stray restarts and limite changes
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 16; a++) rom[a] = 4'(1 << $urandom_range(0, 3));
            lim = int'($urandom_range(0, 15));
            run_seq(lim, int'($urandom_range(1, (lim + 1) * P)), 1'b1, $sformatf("rnd%0d", r));
        end

`ifdef VALIDA_ONEHOT_EN
        rom_padrao();
        rom[1] = 4'b0011;
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.limite  = AW'(3);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clock);
            bus.iniciar = 1'b0;
            check_obs($sformatf("onehot_k%0d", k), modelo(k, 3));
        end
        @(negedge clock);
        check_obs("onehot_fim", obs_t'({1'b0, 4'b0000, AW'(1), 1'b1, 1'b1}));
        check_int("onehot_erro_set", int'(bus.erro), 1);
        @(negedge clock);
        check_obs("onehot_idle", obs_t'({1'b0, 4'b0000, AW'(1), 1'b0, 1'b0}));
        repeat (3) @(negedge clock);
        check_int("onehot_erro_sticky", int'(bus.erro), 1);
        $display("TXN onehot_abort limite=3 bad_addr=1");
        rom[1] = 4'b0010;
        run_seq(3, -1, 1'b0, "onehot_clear");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
